fwd_hazard_unit: RTL

//  Producer end of the execute-stage operand-forwarding interface. Tracks in-flight destination tags.

---
 rtl/pipe_pkg.sv | 34 +++
 rtl/fwd_operand_sel.sv | 41 ++++
 rtl/fwd_hazard_unit.sv | 100 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the execute-stage forwarding and hazard logic.
// A tag describes one in-flight instruction's destination; a src record describes EX operands.
package pipe_pkg;

   localparam int RA_W = 4;
   localparam int VA_W = 3;
   localparam int D_W  = 32;
   localparam int VD_W = 128;

   typedef struct packed {
      logic            valid;
      logic            we;
      logic            vec;
      logic [RA_W-1:0] rd;
      logic            is_load;
   } fwd_tag_t;

   typedef struct packed {
      logic [RA_W-1:0] rs1;
      logic [RA_W-1:0] rs2;
      logic            vec1;
      logic            vec2;
   } fwd_src_t;

   // Vector addresses compare only their low VA_W bits; scalar r0 never matches.
   function automatic logic tag_match(input logic [RA_W-1:0] src,
                                      input logic            svec,
                                      input fwd_tag_t        t);
      logic addr_eq;
      addr_eq = svec ? (t.rd[VA_W-1:0] == src[VA_W-1:0]) : (t.rd == src);
      return t.valid & t.we & (t.vec == svec) & addr_eq & (svec | (src != '0));
   endfunction

endpackage

// File: rtl/fwd_operand_sel.sv
// One-operand forwarding matcher and bypass mux against the MEM and WB tags.
// Scalar sources drive only the scalar output, vector sources only the vector output.
module fwd_operand_sel
   import pipe_pkg::*;
(
   input  logic [RA_W-1:0] src,
   input  logic            svec,
   input  fwd_tag_t        mem_t,
   input  fwd_tag_t        wb_t,
   input  logic [D_W-1:0]  mem_result,
   input  logic [VD_W-1:0] mem_vresult,
   input  logic [D_W-1:0]  wb_result,
   input  logic [VD_W-1:0] wb_vresult,
   output logic            fwd,
   output logic [D_W-1:0]  data,
   output logic [VD_W-1:0] vdata
);

   logic hit_mem;
   logic hit_wb;

   // A load in MEM only holds its address, so it can never be a bypass source.
   assign hit_mem = tag_match(src, svec, mem_t) & ~mem_t.is_load;
   assign hit_wb  = tag_match(src, svec, wb_t);

   always_comb begin
      fwd   = 1'b0;
      data  = '0;
      vdata = '0;
      if (hit_mem) begin
         fwd = 1'b1;
         if (svec) vdata = mem_vresult;
         else      data  = mem_result;
      end else if (hit_wb) begin
         fwd = 1'b1;
         if (svec) vdata = wb_vresult;
         else      data  = wb_result;
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard unit feeding the execute stage.
// Keeps a shadow tag pipeline for EX/MEM/WB and stalls decode one cycle on load-use.
module fwd_hazard_unit
   import pipe_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [RA_W-1:0]  id_rs1,
   input  logic [RA_W-1:0]  id_rs2,
   input  logic             id_rs1_vec,
   input  logic             id_rs2_vec,
   input  logic [RA_W-1:0]  id_rd,
   input  logic             id_rd_vec,
   input  logic             id_we,
   input  logic             id_is_load,
   input  logic             flush,
   input  logic [D_W-1:0]   mem_result,
   input  logic [VD_W-1:0]  mem_vresult,
   input  logic [D_W-1:0]   wb_result,
   input  logic [VD_W-1:0]  wb_vresult,
   output logic             OpAForward,
   output logic             OpBForward,
   output logic [D_W-1:0]   forwarded1,
   output logic [D_W-1:0]   forwarded2,
   output logic [VD_W-1:0]  forwardedV1,
   output logic [VD_W-1:0]  forwardedV2,
   output logic             stall,
   output logic             ex_bubble,
   output logic [CNT_W-1:0] stall_cnt
);

   fwd_tag_t ex_t;
   fwd_tag_t mem_t;
   fwd_tag_t wb_t;
   fwd_src_t ex_src;

   // The load's result only exists at WB, so a dependent in decode waits one cycle.
   assign stall = id_valid & ~flush & ex_t.is_load &
                  (tag_match(id_rs1, id_rs1_vec, ex_t) | tag_match(id_rs2, id_rs2_vec, ex_t));

   assign ex_bubble = ~ex_t.valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_t   <= '0;
         mem_t  <= '0;
         wb_t   <= '0;
         ex_src <= '0;
      end else begin
         wb_t  <= mem_t;
         mem_t <= ex_t;
         if (flush || stall) begin
            ex_t <= '0;
         end else begin
            ex_t   <= '{valid: id_valid, we: id_we, vec: id_rd_vec, rd: id_rd, is_load: id_is_load};
            ex_src <= '{rs1: id_rs1, rs2: id_rs2, vec1: id_rs1_vec, vec2: id_rs2_vec};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

   fwd_operand_sel u_sel_a (
      .src         (ex_src.rs1),
      .svec        (ex_src.vec1),
      .mem_t       (mem_t),
      .wb_t        (wb_t),
      .mem_result  (mem_result),
      .mem_vresult (mem_vresult),
      .wb_result   (wb_result),
      .wb_vresult  (wb_vresult),
      .fwd         (OpAForward),
      .data        (forwarded1),
      .vdata       (forwardedV1)
   );

   fwd_operand_sel u_sel_b (
      .src         (ex_src.rs2),
      .svec        (ex_src.vec2),
      .mem_t       (mem_t),
      .wb_t        (wb_t),
      .mem_result  (mem_result),
      .mem_vresult (mem_vresult),
      .wb_result   (wb_result),
      .wb_vresult  (wb_vresult),
      .fwd         (OpBForward),
      .data        (forwarded2),
      .vdata       (forwardedV2)
   );

endmodule
